// File: rtl/btb_ctrl.sv
// Branch target buffer controller: 8 sets x 2 ways, power-on/flush invalidate sweep,
// and a two-cycle read-modify-write update path alongside lookup-side LRU writes.
module btb_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_valid,
    input  logic [31:0]  if_pc,
    output logic [127:0] rd_set,
    output logic [7:0]   rd_lru,
    output logic [26:0]  rd_tag,
    output logic [2:0]   rd_index,
    input  logic         lru_next,
    input  logic         upd_valid,
    output logic         upd_ready,
    input  logic [31:0]  upd_pc,
    input  logic [31:0]  upd_target,
    input  logic         upd_taken,
    input  logic         flush,
    output logic         busy
);

    localparam int unsigned SETS  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TAG_W = 27;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned ENT_W = 64;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_WR = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_init_cnt;
    logic               r_busy;
    logic               r_upd_ready;
    logic [IDX_W-1:0]   r_cap_idx;
    logic [TAG_W-1:0]   r_cap_tag;
    logic [PC_W-1:0]    r_cap_target;
    logic               r_cap_taken;
    logic [SETS-1:0]    r_lru;
    logic [ENT_W-1:0]   r_way1 [SETS];
    logic [ENT_W-1:0]   r_way2 [SETS];

    logic [ENT_W-1:0]   w_e1;
    logic [ENT_W-1:0]   w_e2;
    logic               w_hit1;
    logic               w_hit2;
    logic               w_wr1;
    logic               w_wr2;
    logic [ENT_W-1:0]   w_new;
    logic               w_do_upd;
    logic               w_do_clr;
    logic               w_unused;

    // 2-bit direction counter: taken walks 00->01->11->10, not-taken walks back
    function automatic logic [1:0] next_st(input logic [1:0] st, input logic tk);
        logic [1:0] ns;
        ns = st;
        case ({tk, st})
            3'b1_00: ns = 2'b01;
            3'b1_01: ns = 2'b11;
            3'b1_11: ns = 2'b10;
            3'b1_10: ns = 2'b10;
            3'b0_10: ns = 2'b11;
            3'b0_11: ns = 2'b01;
            3'b0_01: ns = 2'b00;
            default: ns = 2'b00;
        endcase
        return ns;
    endfunction

    function automatic logic [ENT_W-1:0] hit_entry(input logic [ENT_W-1:0] e,
                                                   input logic tk,
                                                   input logic [PC_W-1:0] tgt);
        return {e[63:36], (tk ? tgt : e[35:4]), next_st(e[3:2], tk), 2'b00};
    endfunction

    function automatic logic [ENT_W-1:0] clr_entry(input logic [ENT_W-1:0] e);
        return {1'b0, e[62:4], 2'b00, 2'b00};
    endfunction

    assign w_e1     = r_way1[r_cap_idx];
    assign w_e2     = r_way2[r_cap_idx];
    assign w_hit1   = w_e1[63] && (w_e1[62:36] == r_cap_tag);
    assign w_hit2   = w_e2[63] && (w_e2[62:36] == r_cap_tag);
    assign w_do_upd = (r_state == ST_UPD_WR) && !flush;
    assign w_do_clr = (r_state == ST_INIT) && !flush;
    assign w_unused = ^{if_pc[1:0], upd_pc[1:0], w_e1[1:0], w_e2[1:0]};

    // Update decision for the captured set: hit (way1 first), allocate on taken miss
    always_comb begin
        w_wr1 = 1'b0;
        w_wr2 = 1'b0;
        w_new = '0;
        if (w_hit1) begin
            w_wr1 = 1'b1;
            w_new = hit_entry(w_e1, r_cap_taken, r_cap_target);
        end else if (w_hit2) begin
            w_wr2 = 1'b1;
            w_new = hit_entry(w_e2, r_cap_taken, r_cap_target);
        end else if (r_cap_taken) begin
            w_new = {1'b1, r_cap_tag, r_cap_target, 2'b11, 2'b00};
            if (!w_e1[63])             w_wr1 = 1'b1;
            else if (!w_e2[63])        w_wr2 = 1'b1;
            else if (r_lru[r_cap_idx]) w_wr1 = 1'b1;
            else                       w_wr2 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_busy       <= 1'b1;
            r_upd_ready  <= 1'b0;
            r_cap_idx    <= '0;
            r_cap_tag    <= '0;
            r_cap_target <= '0;
            r_cap_taken  <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_busy      <= 1'b1;
            r_upd_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + IDX_W'(1);
                    if (r_init_cnt == IDX_W'(SETS - 1)) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_upd_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (upd_valid && r_upd_ready) begin
                        r_cap_idx    <= upd_pc[4:2];
                        r_cap_tag    <= upd_pc[31:5];
                        r_cap_target <= upd_target;
                        r_cap_taken  <= upd_taken;
                        r_state      <= ST_UPD_WR;
                        r_upd_ready  <= 1'b0;
                    end
                end
                ST_UPD_WR: begin
                    r_state     <= ST_IDLE;
                    r_upd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_cnt  <= '0;
                    r_busy      <= 1'b1;
                    r_upd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Entry storage is deliberately unreset; the sweep invalidates it
    always_ff @(posedge clk) begin
        if (w_do_clr) begin
            r_way1[r_init_cnt] <= clr_entry(r_way1[r_init_cnt]);
            r_way2[r_init_cnt] <= clr_entry(r_way2[r_init_cnt]);
        end
        if (w_do_upd && w_wr1) r_way1[r_cap_idx] <= w_new;
        if (w_do_upd && w_wr2) r_way2[r_cap_idx] <= w_new;
    end

    // Update-side LRU write is placed last so it wins a same-index collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lru <= '0;
        end else begin
            if ((r_state != ST_INIT) && if_valid) r_lru[rd_index] <= lru_next;
            if (w_do_upd && (w_wr1 || w_wr2))     r_lru[r_cap_idx] <= w_wr2;
        end
    end

    assign rd_tag    = if_pc[31:5];
    assign rd_index  = if_pc[4:2];
    assign rd_set    = (r_state == ST_INIT) ? '0 : {r_way1[rd_index], r_way2[rd_index]};
    assign rd_lru    = r_lru;
    assign busy      = r_busy;
    assign upd_ready = r_upd_ready;

endmodule

// File: tb/tb_btb_ctrl.sv
// Scoreboard bench for btb_ctrl: directed updates/flushes push expected read-port
// snapshots; a negedge monitor pops and compares them.
module tb_btb_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         if_valid;
    logic [31:0]  if_pc;
    logic [127:0] rd_set;
    logic [7:0]   rd_lru;
    logic [26:0]  rd_tag;
    logic [2:0]   rd_index;
    logic         lru_next;
    logic         upd_valid;
    logic         upd_ready;
    logic [31:0]  upd_pc;
    logic [31:0]  upd_target;
    logic         upd_taken;
    logic         flush;
    logic         busy;

    localparam logic [127:0] ALL    = {128{1'b1}};
    localparam logic [127:0] NONE   = 128'h0;
    localparam logic [127:0] VMASK  = {64'h8000_0000_0000_000C, 64'h8000_0000_0000_000C};
    localparam logic [127:0] W1MASK = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_000C};

    btb_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .rd_set     (rd_set),
        .rd_lru     (rd_lru),
        .rd_tag     (rd_tag),
        .rd_index   (rd_index),
        .lru_next   (lru_next),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .flush      (flush),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    string        q_name [$];
    logic [127:0] q_set  [$];
    logic [127:0] q_mask [$];
    logic [7:0]   q_lru  [$];
    logic [1:0]   q_br   [$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         chk   = 1'b0;

    function automatic logic [63:0] ent(input logic [26:0] tag, input logic [31:0] tgt,
                                        input logic [1:0] st);
        return {1'b1, tag, tgt, st, 2'b00};
    endfunction

    // Queue one expected snapshot for the set at idx and let one clock edge pass
    task automatic probe(input string nm, input logic [2:0] idx, input logic [127:0] es,
                         input logic [127:0] em, input logic [7:0] el,
                         input logic eb, input logic er);
        if_pc = {27'h0, idx, 2'b00};
        q_name.push_back(nm);
        q_set.push_back(es);
        q_mask.push_back(em);
        q_lru.push_back(el);
        q_br.push_back({eb, er});
        chk = 1'b1;
        @(posedge clk);
        #1 chk = 1'b0;
    endtask

    // Accept cycle then UPD_WR cycle, with an optional lookup during UPD_WR
    task automatic upd(input string nm, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic [7:0] lru_pre,
                       input logic lk_v, input logic [2:0] lk_idx, input logic lk_nx);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        probe({nm, "_accept"}, pc[4:2], NONE, NONE, lru_pre, 1'b0, 1'b1);
        upd_valid  = 1'b0;
        upd_pc     = 32'hDEAD_BEE0;
        upd_target = 32'hFFFF_FFF0;
        upd_taken  = ~tk;
        if_valid   = lk_v;
        lru_next   = lk_nx;
        probe({nm, "_updwr"}, lk_idx, NONE, NONE, lru_pre, 1'b0, 1'b0);
        if_valid   = 1'b0;
        lru_next   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            n_cmp++;
            if (q_name.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: probe with no expected entry");
            end else begin
                string        nm;
                logic [127:0] es;
                logic [127:0] em;
                logic [7:0]   el;
                logic [1:0]   ebr;
                nm  = q_name.pop_front();
                es  = q_set.pop_front();
                em  = q_mask.pop_front();
                el  = q_lru.pop_front();
                ebr = q_br.pop_front();
                if (((rd_set & em) != (es & em)) || (rd_lru != el) || ({busy, upd_ready} != ebr)) begin
                    n_err++;
                    $display("FAIL %s: rd_set=%h want=%h (mask %h) lru=%h want=%h busy,rdy=%b want=%b",
                             nm, rd_set, es, em, rd_lru, el, {busy, upd_ready}, ebr);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        if_valid   = 1'b0;
        if_pc      = 32'h0;
        lru_next   = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        upd_taken  = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        probe("in_reset", 3'd0, NONE, ALL, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) probe("init_sweep", 3'(i), NONE, ALL, 8'h00, 1'b1, 1'b0);
        probe("init_done", 3'd0, NONE, VMASK, 8'h00, 1'b0, 1'b1);

        // Allocate, then walk the direction counter on the same branch
        upd("alloc", 32'h100, 32'h200, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("alloc_rd", 3'd0, {ent(27'h8, 32'h200, 2'b11), 64'h0}, W1MASK, 8'h00, 1'b0, 1'b1);
        upd("tk1", 32'h100, 32'h300, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("tk1_rd", 3'd0, {ent(27'h8, 32'h300, 2'b10), 64'h0}, W1MASK, 8'h00, 1'b0, 1'b1);
        upd("tk2", 32'h100, 32'h300, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("tk2_rd", 3'd0, {ent(27'h8, 32'h300, 2'b10), 64'h0}, W1MASK, 8'h00, 1'b0, 1'b1);
        upd("nt1", 32'h100, 32'h999, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("nt1_rd", 3'd0, {ent(27'h8, 32'h300, 2'b11), 64'h0}, W1MASK, 8'h00, 1'b0, 1'b1);
        upd("nt2", 32'h100, 32'h999, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("nt2_rd", 3'd0, {ent(27'h8, 32'h300, 2'b01), 64'h0}, W1MASK, 8'h00, 1'b0, 1'b1);
        upd("nt3", 32'h100, 32'h999, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("nt3_rd", 3'd0, {ent(27'h8, 32'h300, 2'b00), 64'h0}, W1MASK, 8'h00, 1'b0, 1'b1);

        // Replacement in set 0
        upd("alloc_w2", 32'h200, 32'h400, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("alloc_w2_rd", 3'd0, {ent(27'h8, 32'h300, 2'b00), ent(27'h10, 32'h400, 2'b11)}, ALL, 8'h01, 1'b0, 1'b1);
        upd("repl_w1", 32'h300, 32'h500, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0);
        probe("repl_w1_rd", 3'd0, {ent(27'h18, 32'h500, 2'b11), ent(27'h10, 32'h400, 2'b11)}, ALL, 8'h00, 1'b0, 1'b1);
        upd("miss_nt", 32'h400, 32'h600, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("miss_nt_rd", 3'd0, {ent(27'h18, 32'h500, 2'b11), ent(27'h10, 32'h400, 2'b11)}, ALL, 8'h00, 1'b0, 1'b1);
        upd("repl_w2", 32'h500, 32'h700, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        probe("repl_w2_rd", 3'd0, {ent(27'h18, 32'h500, 2'b11), ent(27'h28, 32'h700, 2'b11)}, ALL, 8'h01, 1'b0, 1'b1);

        // LRU write collisions between update and lookup
        upd("lru_diff", 32'h0C, 32'h10, 1'b1, 8'h01, 1'b1, 3'd5, 1'b1);
        probe("lru_diff_rd", 3'd3, {ent(27'h0, 32'h10, 2'b11), 64'h0}, W1MASK, 8'h21, 1'b0, 1'b1);
        upd("lru_same", 32'h2C, 32'h20, 1'b1, 8'h21, 1'b1, 3'd3, 1'b0);
        probe("lru_same_rd", 3'd3, {ent(27'h0, 32'h10, 2'b11), ent(27'h1, 32'h20, 2'b11)}, ALL, 8'h29, 1'b0, 1'b1);

        // Flush with a simultaneous update request; lookups during the sweep are ignored
        flush      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_target = 32'h200;
        upd_taken  = 1'b1;
        probe("flush_idle", 3'd0, NONE, NONE, 8'h29, 1'b0, 1'b1);
        flush     = 1'b0;
        upd_valid = 1'b0;
        if_valid  = 1'b1;
        lru_next  = 1'b1;
        for (int i = 0; i < 8; i++) probe("flush_sweep", 3'(i), NONE, ALL, 8'h29, 1'b1, 1'b0);
        if_valid  = 1'b0;
        lru_next  = 1'b0;
        probe("flush_done", 3'd0, NONE, VMASK, 8'h29, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) probe("flush_clean", 3'(i), NONE, VMASK, 8'h29, 1'b0, 1'b1);

        // Flush during UPD_WR discards the pending write
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_target = 32'h200;
        upd_taken  = 1'b1;
        probe("fwr_accept", 3'd0, NONE, NONE, 8'h29, 1'b0, 1'b1);
        upd_valid = 1'b0;
        flush     = 1'b1;
        probe("fwr_flush", 3'd0, NONE, NONE, 8'h29, 1'b0, 1'b0);
        flush = 1'b0;
        for (int i = 0; i < 8; i++) probe("fwr_sweep", 3'(i), NONE, ALL, 8'h29, 1'b1, 1'b0);
        probe("fwr_done", 3'd0, NONE, VMASK, 8'h29, 1'b0, 1'b1);

        @(posedge clk);
        if (q_name.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q_name.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
